// File: rtl/huffman_param_pkg.sv
// Shared types and elaboration helpers for the parametrised Huffman coder.
package huffman_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_REPORT,
    S_BUILD,
    S_DONE
  } state_t;

  // Ceiling log2, with clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Merged node weights must hold NSYM saturated counts without overflow.
  function automatic int weight_width(input int cw, input int nsym);
    return cw + clog2(nsym);
  endfunction

endpackage

// File: rtl/huffman_min2.sv
// Combinational selector for the two lightest active nodes (ties -> highest index).
module huffman_min2
  import huffman_param_pkg::*;
#(
  parameter int NSYM = 6,
  parameter int WW   = 11,
  parameter int IW   = clog2(NSYM)
) (
  input  logic [NSYM*WW-1:0] i_weight,
  input  logic [NSYM-1:0]    i_active,
  output logic [IW-1:0]      o_a,
  output logic [IW-1:0]      o_b
);

  logic [WW-1:0] w_best_a;
  logic [WW-1:0] w_best_b;
  logic          w_found_a;
  logic          w_found_b;

  // '<=' while scanning upward lets a later equal weight win the tie.
  always_comb begin
    o_a       = '0;
    o_b       = '0;
    w_best_a  = '0;
    w_best_b  = '0;
    w_found_a = 1'b0;
    w_found_b = 1'b0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      if (i_active[k] && (!w_found_a || i_weight[k*WW +: WW] <= w_best_a)) begin
        o_a       = IW'(k);
        w_best_a  = i_weight[k*WW +: WW];
        w_found_a = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NSYM; k++) begin
      if (i_active[k] && (IW'(k) != o_a) &&
          (!w_found_b || i_weight[k*WW +: WW] <= w_best_b)) begin
        o_b       = IW'(k);
        w_best_b  = i_weight[k*WW +: WW];
        w_found_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/huffman_param.sv
// Frame histogram plus iterative two-minimum Huffman code builder, one merge per cycle.
module huffman_param
  import huffman_param_pkg::*;
#(
  parameter int NSYM = 6,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int LW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gray_valid,
  input  logic [DW-1:0]      gray_data,
  output logic               in_ready,
  output logic               CNT_valid,
  output logic [NSYM*CW-1:0] CNT,
  output logic               code_valid,
  output logic [NSYM*LW-1:0] HC,
  output logic [NSYM*LW-1:0] M
);

  localparam int IW   = clog2(NSYM);
  localparam int WW   = weight_width(CW, NSYM);
  localparam int LENW = clog2(LW + 1);

  if (NSYM < 2) begin : g_bad_nsym
    $error("huffman_param: NSYM must be at least 2");
  end
  if (NSYM - 1 > LW) begin : g_bad_lw
    $error("huffman_param: LW must be at least NSYM-1");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt     [NSYM];
  logic [CW-1:0]   r_cnt_out [NSYM];
  logic [WW-1:0]   r_weight  [NSYM];
  logic [NSYM-1:0] r_member  [NSYM];
  logic [LENW-1:0] r_len     [NSYM];
  logic [LW-1:0]   r_hc      [NSYM];
  logic [LW-1:0]   r_m       [NSYM];
  logic [NSYM-1:0] r_active;
  logic [IW-1:0]   r_round;
  logic            r_in_ready;
  logic            r_cnt_valid;
  logic            r_code_valid;

  logic [NSYM*WW-1:0] w_weight_flat;
  logic [IW-1:0]      w_a;
  logic [IW-1:0]      w_b;
  logic               w_in_range;
  logic [IW-1:0]      w_sym;

  assign w_in_range = (gray_data != '0) && (gray_data <= DW'(NSYM));
  assign w_sym      = IW'(gray_data - 1'b1);

  for (genvar k = 0; k < NSYM; k++) begin : g_flat
    assign w_weight_flat[k*WW +: WW] = r_weight[k];
    assign CNT[k*CW +: CW]           = r_cnt_out[k];
    assign HC[k*LW +: LW]            = r_hc[k];
    assign M[k*LW +: LW]             = r_m[k];
  end

  huffman_min2 #(.NSYM(NSYM), .WW(WW), .IW(IW)) u_min2 (
    .i_weight (w_weight_flat),
    .i_active (r_active),
    .o_a      (w_a),
    .o_b      (w_b)
  );

  assign in_ready   = r_in_ready;
  assign CNT_valid  = r_cnt_valid;
  assign code_valid = r_code_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b1;
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      r_round      <= '0;
      r_active     <= '0;
      for (int unsigned k = 0; k < NSYM; k++) begin
        r_cnt[k]     <= '0;
        r_cnt_out[k] <= '0;
        r_weight[k]  <= '0;
        r_member[k]  <= '0;
        r_len[k]     <= '0;
        r_hc[k]      <= '0;
        r_m[k]       <= '0;
      end
    end else begin
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (gray_valid) begin
            for (int unsigned k = 0; k < NSYM; k++)
              r_cnt[k] <= (w_in_range && w_sym == IW'(k)) ? CW'(1) : '0;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (gray_valid) begin
            if (w_in_range && r_cnt[w_sym] != '1)
              r_cnt[w_sym] <= r_cnt[w_sym] + 1'b1;
          end else begin
            for (int unsigned k = 0; k < NSYM; k++)
              r_cnt_out[k] <= r_cnt[k];
            r_cnt_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          for (int unsigned k = 0; k < NSYM; k++) begin
            r_weight[k] <= WW'(r_cnt[k]);
            r_member[k] <= NSYM'(1) << k;
            r_len[k]    <= '0;
            r_hc[k]     <= '0;
            r_m[k]      <= '0;
          end
          r_active <= '1;
          r_round  <= '0;
          r_state  <= S_BUILD;
        end
        S_BUILD: begin
          // B members take a 0 bit: HC was cleared at REPORT, so only the mask grows.
          for (int unsigned k = 0; k < NSYM; k++) begin
            if (r_member[w_a][k]) begin
              r_hc[k]  <= r_hc[k] | (LW'(1) << r_len[k]);
              r_m[k]   <= r_m[k] | (LW'(1) << r_len[k]);
              r_len[k] <= r_len[k] + 1'b1;
            end else if (r_member[w_b][k]) begin
              r_m[k]   <= r_m[k] | (LW'(1) << r_len[k]);
              r_len[k] <= r_len[k] + 1'b1;
            end
          end
          r_weight[w_b] <= r_weight[w_a] + r_weight[w_b];
          r_member[w_b] <= r_member[w_a] | r_member[w_b];
          r_active[w_a] <= 1'b0;
          r_round       <= r_round + 1'b1;
          if (r_round == IW'(NSYM - 2)) begin
            r_code_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_param.sv
// Self-checking bench: two parametrisations against a histogram/Huffman reference model.
module tb_huffman_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v6, rdy6, cv6, codev6;
  logic [7:0]  d6;
  logic [47:0] cnt6, hc6, m6;
  logic        v8, rdy8, cv8, codev8;
  logic [7:0]  d8;
  logic [79:0] cnt8;
  logic [63:0] hc8, m8;
  logic [65:0] mw;
  logic [5:0]  mact;
  logic [2:0]  ma, mb;

  huffman_param u6 (
    .clk(clk), .reset(reset), .gray_valid(v6), .gray_data(d6), .in_ready(rdy6),
    .CNT_valid(cv6), .CNT(cnt6), .code_valid(codev6), .HC(hc6), .M(m6)
  );

  huffman_param #(.NSYM(8), .DW(8), .CW(10), .LW(8)) u8 (
    .clk(clk), .reset(reset), .gray_valid(v8), .gray_data(d8), .in_ready(rdy8),
    .CNT_valid(cv8), .CNT(cnt8), .code_valid(codev8), .HC(hc8), .M(m8)
  );

  huffman_min2 #(.NSYM(6), .WW(11), .IW(3)) u_min2 (
    .i_weight(mw), .i_active(mact), .o_a(ma), .o_b(mb)
  );

  int checks = 0;
  int errors = 0;
  int q_samp[$];
  int exp_cnt[8];
  int exp_hc[8];
  int exp_m[8];
  int s1_cnt[6] = '{30, 20, 15, 15, 10, 10};
  int s1_hc[6]  = '{0, 2, 2, 3, 6, 7};
  int s1_m[6]   = '{3, 3, 7, 7, 7, 7};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit v, input int d);
    if (sel == 8) begin v8 = v; d8 = 8'(d); end
    else begin v6 = v; d6 = 8'(d); end
  endtask

  function automatic logic [63:0] g_cnt(input int sel, input int k);
    if (sel == 8) return 64'(cnt8[k*10 +: 10]);
    return 64'(cnt6[k*8 +: 8]);
  endfunction
  function automatic logic [63:0] g_hc(input int sel, input int k);
    if (sel == 8) return 64'(hc8[k*8 +: 8]);
    return 64'(hc6[k*8 +: 8]);
  endfunction
  function automatic logic [63:0] g_m(input int sel, input int k);
    if (sel == 8) return 64'(m8[k*8 +: 8]);
    return 64'(m6[k*8 +: 8]);
  endfunction
  function automatic logic g_cv(input int sel);    return (sel == 8) ? cv8 : cv6;       endfunction
  function automatic logic g_codev(input int sel); return (sel == 8) ? codev8 : codev6; endfunction
  function automatic logic g_rdy(input int sel);   return (sel == 8) ? rdy8 : rdy6;     endfunction

  // Lightest active node; scanning downward with strict '<' keeps the highest index on ties.
  function automatic int pick(input int w[8], input bit act[8], input int n, input int excl);
    int best = -1;
    for (int k = n - 1; k >= 0; k--)
      if (act[k] && k != excl && (best < 0 || w[k] < w[best])) best = k;
    return best;
  endfunction

  task automatic ref_frame(input int n, input int cw);
    int w[8];
    int grp[8];
    int len[8];
    bit act[8];
    int a, b, s;
    for (int k = 0; k < 8; k++) begin
      exp_cnt[k] = 0; exp_hc[k] = 0; exp_m[k] = 0;
      w[k] = 0; grp[k] = k; len[k] = 0; act[k] = 1'b0;
    end
    foreach (q_samp[i]) begin
      s = q_samp[i];
      if (s >= 1 && s <= n && exp_cnt[s-1] < (1 << cw) - 1) exp_cnt[s-1]++;
    end
    for (int k = 0; k < n; k++) begin w[k] = exp_cnt[k]; act[k] = 1'b1; end
    for (int r = 0; r < n - 1; r++) begin
      a = pick(w, act, n, -1);
      b = pick(w, act, n, a);
      for (int j = 0; j < n; j++) begin
        if (grp[j] == a) begin
          exp_hc[j] |= (1 << len[j]); len[j]++; grp[j] = b;
        end else if (grp[j] == b) begin
          len[j]++;
        end
      end
      w[b] += w[a];
      act[a] = 1'b0;
    end
    for (int k = 0; k < n; k++) exp_m[k] = (1 << len[k]) - 1;
  endtask

  task automatic shuffle_samples();
    int j, t;
    for (int i = q_samp.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = q_samp[i]; q_samp[i] = q_samp[j]; q_samp[j] = t;
    end
  endtask

  task automatic run_frame(input int sel, input int n, input int cw, input string tag,
                           input bit busy_strobe);
    int lat;
    ref_frame(n, cw);
    foreach (q_samp[i]) begin drive(sel, 1'b1, q_samp[i]); step(); end
    drive(sel, 1'b0, 0);
    step();
    chk($sformatf("%s cnt_valid", tag), 64'(g_cv(sel)), 64'd1);
    chk($sformatf("%s rdy_report", tag), 64'(g_rdy(sel)), 64'd0);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s cnt%0d", tag, k + 1), g_cnt(sel, k), 64'(exp_cnt[k]));
    if (busy_strobe) drive(sel, 1'b1, 3);
    step();
    lat = 2;
    chk($sformatf("%s cnt_valid_drop", tag), 64'(g_cv(sel)), 64'd0);
    if (busy_strobe) chk($sformatf("%s rdy_build", tag), 64'(g_rdy(sel)), 64'd0);
    while (g_codev(sel) !== 1'b1 && lat < 40) begin step(); lat++; end
    chk($sformatf("%s code_latency", tag), 64'(lat), 64'(n + 1));
    chk($sformatf("%s rdy_done", tag), 64'(g_rdy(sel)), 64'd0);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s hc%0d", tag, k + 1), g_hc(sel, k), 64'(exp_hc[k]));
      chk($sformatf("%s m%0d", tag, k + 1), g_m(sel, k), 64'(exp_m[k]));
    end
    drive(sel, 1'b0, 0);
    step();
    chk($sformatf("%s code_valid_drop", tag), 64'(g_codev(sel)), 64'd0);
    chk($sformatf("%s rdy_idle", tag), 64'(g_rdy(sel)), 64'd1);
  endtask

  task automatic load_s1();
    q_samp.delete();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < s1_cnt[k]; i++) q_samp.push_back(k + 1);
    shuffle_samples();
  endtask

  task automatic check_s1_consts(input string tag);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s cnt%0d_const", tag, k + 1), g_cnt(6, k), 64'(s1_cnt[k]));
      chk($sformatf("%s hc%0d_const", tag, k + 1), g_hc(6, k), 64'(s1_hc[k]));
      chk($sformatf("%s m%0d_const", tag, k + 1), g_m(6, k), 64'(s1_m[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[8];
    bit act[8];
    int pulses;
    logic [63:0] seen;

    reset = 1'b1; v6 = 1'b0; d6 = '0; v8 = 1'b0; d8 = '0;
    mw = '0; mact = '0;

    // Selector cross-check against the plain-scan reference, small weights to force ties.
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 8; k++) begin w[k] = 0; act[k] = 1'b0; end
      mact = 6'($urandom);
      if ($countones(mact) < 2) mact = mact | 6'b100001;
      for (int k = 0; k < 6; k++) begin
        w[k] = $urandom_range(3, 0);
        act[k] = mact[k];
        mw[k*11 +: 11] = 11'(w[k]);
      end
      #1;
      chk($sformatf("min2 a vec%0d", i), 64'(ma), 64'(pick(w, act, 6, -1)));
      chk($sformatf("min2 b vec%0d", i), 64'(mb), 64'(pick(w, act, 6, pick(w, act, 6, -1))));
    end

    step(); step();
    chk("reset in_ready", 64'(rdy6), 64'd1);
    chk("reset cnt", 64'(cnt6), 64'd0);
    chk("reset hc", 64'(hc6), 64'd0);
    chk("reset m", 64'(m6), 64'd0);
    chk("reset cnt_valid", 64'(cv6), 64'd0);
    chk("reset code_valid", 64'(codev6), 64'd0);
    reset = 1'b0;
    step();

    // Nominal frame.
    load_s1();
    run_frame(6, 6, 8, "s1", 1'b0);
    check_s1_consts("s1");

    // Degenerate frame: only value 1.
    q_samp.delete();
    for (int i = 0; i < 100; i++) q_samp.push_back(1);
    run_frame(6, 6, 8, "s2", 1'b0);
    chk("s2 cnt1_const", g_cnt(6, 0), 64'h64);
    chk("s2 hc1_const", g_hc(6, 0), 64'h00);
    chk("s2 m1_const", g_m(6, 0), 64'h01);
    chk("s2 hc2_const", g_hc(6, 1), 64'h02);
    chk("s2 m2_const", g_m(6, 1), 64'h03);
    chk("s2 hc6_const", g_hc(6, 5), 64'h1F);
    chk("s2 m6_const", g_m(6, 5), 64'h1F);

    // Saturation with out-of-range values interleaved.
    q_samp.delete();
    for (int i = 0; i < 300; i++) begin
      q_samp.push_back(2);
      if (i % 10 == 0) begin q_samp.push_back(0); q_samp.push_back(7); end
    end
    run_frame(6, 6, 8, "s3", 1'b0);
    chk("s3 cnt2_sat", g_cnt(6, 1), 64'hFF);
    chk("s3 cnt1_zero", g_cnt(6, 0), 64'h0);
    chk("s3 cnt6_zero", g_cnt(6, 5), 64'h0);

    // Random frames over the full 0..7 input range.
    for (int f = 0; f < 3; f++) begin
      q_samp.delete();
      for (int i = 0; i < 80; i++) q_samp.push_back($urandom_range(7, 0));
      run_frame(6, 6, 8, $sformatf("rnd%0d", f), 1'b0);
    end

    // Back-pressure: value 3 strobed while busy, then a fresh frame right after DONE.
    load_s1();
    run_frame(6, 6, 8, "s4a", 1'b1);
    q_samp.delete();
    for (int i = 0; i < 5; i++) q_samp.push_back(1);
    run_frame(6, 6, 8, "s4b", 1'b0);
    chk("s4b cnt3_dropped", g_cnt(6, 2), 64'h0);
    chk("s4b cnt1_fresh", g_cnt(6, 0), 64'h5);

    // Reset in the middle of BUILD.
    load_s1();
    foreach (q_samp[i]) begin drive(6, 1'b1, q_samp[i]); step(); end
    drive(6, 1'b0, 0);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5 hc", 64'(hc6), 64'd0);
    chk("s5 m", 64'(m6), 64'd0);
    chk("s5 cnt", 64'(cnt6), 64'd0);
    chk("s5 in_ready", 64'(rdy6), 64'd1);
    chk("s5 code_valid", 64'(codev6), 64'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); if (codev6 === 1'b1) pulses++; end
    chk("s5 no_code_pulse", 64'(pulses), 64'd0);
    load_s1();
    run_frame(6, 6, 8, "s5", 1'b0);
    check_s1_consts("s5");

    // Eight equal counts on the NSYM=8, CW=10 instance.
    q_samp.delete();
    for (int k = 1; k <= 8; k++)
      for (int i = 0; i < 64; i++) q_samp.push_back(k);
    shuffle_samples();
    run_frame(8, 8, 10, "s6", 1'b0);
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s6 cnt%0d_const", k + 1), g_cnt(8, k), 64'd64);
      chk($sformatf("s6 m%0d_const", k + 1), g_m(8, k), 64'h07);
      seen = seen | (64'd1 << g_hc(8, k));
    end
    chk("s6 code_permutation", seen, 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_param.md
Name: huffman_param

Overview:
- Parametrised Huffman coder, the next generation of the fixed 6-symbol gray-level encoder.
- Accumulates a per-symbol histogram over a frame of input samples, reports the counts, then builds a Huffman code for NSYM symbols by iterative two-minimum merging.
- Outputs one code word and one length mask per symbol.
- Adds over the previous generation: parametric symbol count and widths, count saturation, input-ready back-pressure, and back-to-back frames without reset.

Parameters:
- NSYM, 6, number of symbols; legal input values are 1..NSYM.
- DW, 8, width of gray_data.
- CW, 8, per-symbol count width; counts saturate at 2^CW-1.
- LW, 8, code/mask width; elaboration error unless NSYM-1 <= LW.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- gray_valid  in  1  sample strobe.
- gray_data  in  DW  sample value.
- in_ready  out  1  high in IDLE/COUNT; a sample strobed while low is dropped.
- CNT_valid  out  1  one-cycle pulse when the CNT bus is final.
- CNT  out  NSYM*CW  flat counts; symbol k (value k+1) in bits [k*CW +: CW].
- code_valid  out  1  one-cycle pulse when HC/M are final.
- HC  out  NSYM*LW  flat codes, LSB-aligned.
- M  out  NSYM*LW  flat masks, M_k = (1<<len_k)-1.

Behaviour:
- Interface (already decided): one clock clk; reset is synchronous and active-high.
- Reset: state IDLE; all counts, CNT, HC and M = 0; CNT_valid = code_valid = 0; in_ready = 1.
- Reset mid-operation (any state) aborts the frame and applies the same values the next cycle.
- FSM states: IDLE, COUNT, REPORT, BUILD, DONE.
  - IDLE: first cycle with gray_valid=1 clears all counts, applies that sample, and goes to COUNT.
  - COUNT: each gray_valid=1 cycle with 1 <= gray_data <= NSYM increments count[gray_data-1], saturating at 2^CW-1. Out-of-range values are ignored (not counted, no error). The first gray_valid=0 cycle goes to REPORT.
  - REPORT: drive CNT_valid=1 for exactly this cycle. Load node table: weight_k = count_k (width CW+clog2(NSYM)), member_k = one-hot k, active_k = 1. Clear HC/M; len_k = 0. Go to BUILD.
  - BUILD: one merge round per cycle, NSYM-1 rounds total.
  - DONE: code_valid=1 for one cycle, then IDLE. HC/M/CNT hold until the next REPORT or reset.
- Merge round:
  - A = active node with the smallest weight; ties go to the highest index.
  - B = smallest among the remaining active nodes, same tie rule.
  - Every symbol in member_A gets bit 1 written at position len, then len+1. Every symbol in member_B gets bit 0 at position len, then len+1. (Bit prepended at the MSB; codes grow MSB-ward.)
  - Node B becomes weight_A+weight_B, member_A|member_B. Node A is deactivated.
  - Zero-count symbols participate normally.
- Latency from the frame-ending gray_valid=0 cycle:
  - CNT_valid at +1.
  - code_valid at +NSYM+1 (REPORT 1, BUILD NSYM-1, DONE 1).
- in_ready = 0 in REPORT/BUILD/DONE; samples strobed then are dropped.
- A new frame may start in the cycle after DONE.
- NSYM=1 is illegal; elaboration check.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE/COUNT/REPORT/BUILD/DONE);
  - a constant function clog2;
  - localparam WW = CW+clog2(NSYM).
- One natural sub-module: huffman_min2. Combinational; takes NSYM weights plus active bits and returns indices A and B with the highest-index tie rule. Both the top and the bench reference model instantiate it.

Test Plan:
1. Nominal frame (NSYM=6, CW=8, LW=8): 100 samples with counts {30,20,15,15,10,10} for values 1..6, then gray_valid=0.
   - CNT_valid one cycle later with CNT1..6 = 0x1E, 0x14, 0x0F, 0x0F, 0x0A, 0x0A.
   - code_valid 7 cycles after gray_valid drops.
   - HC = 0x00, 0x02, 0x02, 0x03, 0x06, 0x07.
   - M = 0x03, 0x03, 0x07, 0x07, 0x07, 0x07.
2. Degenerate frame: 100 samples of value 1 only.
   - CNT1=0x64, others 0.
   - HC1=0x00 with M1=0x01; HC2=0x02 with M2=0x03; HC6=0x1F with M6=0x1F.
3. Saturation and illegal values: 300 samples of value 2, plus values 0 and 7 interleaved.
   - CNT2=0xFF; all other counts 0.
4. Back-pressure: assert gray_valid with value 3 during BUILD.
   - in_ready=0; the sample is not counted in the next frame.
   - A new frame started the cycle after DONE counts from 0.
5. Reset mid-BUILD: pulse reset.
   - Next cycle: HC=M=CNT=0, in_ready=1, no code_valid pulse.
   - A following scenario-1 frame reproduces scenario-1 results exactly.
6. Parameter sweep NSYM=8, CW=10, LW=8 with 8 equal counts of 64.
   - All M_k = 0x07; codes are a permutation of 0..7.
   - code_valid 9 cycles after the frame ends.
